start_overlay: RTL

START_OVERLAY -- requirements
Module: start_overlay

---
 rtl/start_overlay_if.sv | 40 ++++
 rtl/start_overlay.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/start_overlay_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if (interface)
//  Description : VGA timing/pixel stream bundle. A producer drives the stream
//                through the out/master modport and a consumer samples it
//                through the in/slave modport.
//                  hcount[10:0], vcount[10:0] : pixel position
//                  hsync, vsync               : sync pulses
//                  hblnk, vblnk               : blanking flags
//                  rgb[11:0]                  : 4:4:4 pixel colour
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  // Consumer side of the stream
  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  // Producer side of the stream
  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface
`default_nettype wire

// File: rtl/start_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : start_overlay
//  Description : Blinking start-screen text overlay for a VGA stream.
//                The incoming timing stream is delayed by TEXT_LAT cycles so
//                that it lines up with the text draw stage, then merged with
//                the text pixels and registered once more onto vout.
//                A small FSM (HIDDEN / VISIBLE / BLANKED) advances only on
//                frame boundaries, so the overlay never tears mid-frame.
//  Ports       :
//    clk        in   pixel clock, rising edge
//    rst        in   asynchronous active-high reset
//    vin        in   vga_if.in  - incoming timing/pixel stream
//    text_rgb   in   [11:0] text pixel, aligned with the delayed stream
//    text_valid in   text_rgb lies inside the text rectangle
//    enable     in   game is in its start-screen state
//    vout       out  vga_if.out - merged stream, vin latency TEXT_LAT+1
//    shown      out  high while the FSM is in VISIBLE
//  Revision    : 1.0 - initial release
// ============================================================================
module start_overlay #(
  parameter int          TEXT_LAT     = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] KEY_RGB      = 12'hF0F,
  parameter int          DIM_BG       = 1
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vin,
  input  logic [11:0] text_rgb,
  input  logic        text_valid,
  input  logic        enable,
  vga_if.out          vout,
  output logic        shown
);

  // Flattened stream word: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  localparam int         c_W    = 38;
  localparam logic [7:0] c_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    HIDDEN  = 2'd0,
    VISIBLE = 2'd1,
    BLANKED = 2'd2
  } state_t;

  logic [c_W-1:0] r_dly [TEXT_LAT];
  logic [c_W-1:0] w_vin_flat;

  logic [10:0] w_d_hcount;
  logic [10:0] w_d_vcount;
  logic        w_d_hsync;
  logic        w_d_vsync;
  logic        w_d_hblnk;
  logic        w_d_vblnk;
  logic [11:0] w_d_rgb;

  logic        r_vblnk_prev;
  logic        w_frame;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_shown;

  logic [11:0] w_dim;
  logic [11:0] w_rgb;

  assign w_vin_flat = {vin.hcount, vin.vcount, vin.hsync, vin.vsync,
                       vin.hblnk, vin.vblnk, vin.rgb};

  // --------------------------------------------------------------------------
  // Alignment delay line
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TEXT_LAT; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_dly[0] <= w_vin_flat;
      for (int i = 1; i < TEXT_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_d_hcount = r_dly[TEXT_LAT-1][37:27];
  assign w_d_vcount = r_dly[TEXT_LAT-1][26:16];
  assign w_d_hsync  = r_dly[TEXT_LAT-1][15];
  assign w_d_vsync  = r_dly[TEXT_LAT-1][14];
  assign w_d_hblnk  = r_dly[TEXT_LAT-1][13];
  assign w_d_vblnk  = r_dly[TEXT_LAT-1][12];
  assign w_d_rgb    = r_dly[TEXT_LAT-1][11:0];

  // One pulse per frame: rising edge of the aligned vblnk.
  assign w_frame = w_d_vblnk & ~r_vblnk_prev;

  // --------------------------------------------------------------------------
  // Blink FSM. enable is only sampled on a frame boundary so that a change
  // in the middle of a frame cannot tear the picture. Dropping enable wins
  // over a blink toggle on the same boundary.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_state      <= HIDDEN;
      r_cnt        <= 8'd0;
      r_shown      <= 1'b0;
    end else begin
      r_vblnk_prev <= w_d_vblnk;
      if (w_frame) begin
        if (!enable) begin
          r_state <= HIDDEN;
          r_cnt   <= 8'd0;
          r_shown <= 1'b0;
        end else begin
          case (r_state)
            HIDDEN: begin
              r_state <= VISIBLE;
              r_cnt   <= 8'd0;
              r_shown <= 1'b1;
            end
            VISIBLE: begin
              if (r_cnt == c_LAST) begin
                r_state <= BLANKED;
                r_cnt   <= 8'd0;
                r_shown <= 1'b0;
              end else begin
                r_cnt   <= r_cnt + 8'd1;
              end
            end
            BLANKED: begin
              if (r_cnt == c_LAST) begin
                r_state <= VISIBLE;
                r_cnt   <= 8'd0;
                r_shown <= 1'b1;
              end else begin
                r_cnt   <= r_cnt + 8'd1;
              end
            end
            default: begin
              r_state <= HIDDEN;
              r_cnt   <= 8'd0;
              r_shown <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign shown = r_shown;

  // --------------------------------------------------------------------------
  // Pixel mux. Blanking forces black; otherwise opaque text wins in VISIBLE,
  // and the background is halved per channel whenever the overlay is active.
  // --------------------------------------------------------------------------
  always_comb begin
    w_dim = {1'b0, w_d_rgb[11:9], 1'b0, w_d_rgb[7:5], 1'b0, w_d_rgb[3:1]};
    w_rgb = w_d_rgb;
    if (w_d_hblnk || w_d_vblnk) begin
      w_rgb = 12'h000;
    end else if ((r_state == VISIBLE) && text_valid && (text_rgb != KEY_RGB)) begin
      w_rgb = text_rgb;
    end else if ((r_state != HIDDEN) && (DIM_BG != 0)) begin
      w_rgb = w_dim;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout.hcount <= 11'd0;
      vout.vcount <= 11'd0;
      vout.hsync  <= 1'b0;
      vout.vsync  <= 1'b0;
      vout.hblnk  <= 1'b0;
      vout.vblnk  <= 1'b0;
      vout.rgb    <= 12'h000;
    end else begin
      vout.hcount <= w_d_hcount;
      vout.vcount <= w_d_vcount;
      vout.hsync  <= w_d_hsync;
      vout.vsync  <= w_d_vsync;
      vout.hblnk  <= w_d_hblnk;
      vout.vblnk  <= w_d_vblnk;
      vout.rgb    <= w_rgb;
    end
  end

endmodule
`default_nettype wire
